vga_fault_monitor: RTL and testbench
====================================

VGA_FAULT_MONITOR -- requirements
Module: vga_fault_monitor

Interface
REQ-001 Parameter DEFAULT_THRESH, default 4, reset value of CTRL.THRESH.
REQ-002 HCLK  in  1  single clock; all state updates on rising edge.
REQ-003 HRESET  in  1  synchronous, active-high reset.
REQ-004 HSEL  in  1  AHB-Lite slave select.
REQ-005 HADDR  in  32  address; only HADDR[3:2] decoded.
REQ-006 HTRANS  in  2  transfer type; HTRANS[1]=1 means valid transfer.
REQ-007 HWRITE  in  1  1 = write.
REQ-008 HREADY  in  1  bus ready.
REQ-009 HWDATA  in  32  write data, data phase.
REQ-010 HRDATA  out  32  read data, data phase.
REQ-011 HREADYOUT  out  1  always 1 (zero wait states).
REQ-012 DLS_ERROR  in  1  registered mismatch flag from the lockstep VGA pair.
REQ-013 RGB_IN  in  8  primary VGA pixel data.
REQ-014 RGB_OUT  out  8  pixel data to the display pins.
REQ-015 FAULT_IRQ  out  1  fault interrupt, level.

Function
REQ-016 Valid access: HSEL & HREADY & HTRANS[1]; address phase latches HADDR[3:2], HWRITE and valid into registers; the write takes effect at the end of the following (data-phase) cycle.
REQ-017 Register map: 0x0 STATUS (RO), 0x4 ERRCNT (RO), 0x8 CTRL (RW), 0xC CLEAR (WO, reads 0).
REQ-018 STATUS: [0]=FAULT, [1]=live DLS_ERROR, [2]=FAULT_IRQ, [3]=state==SUSPECT, [15:8]=RUN; other bits 0.
REQ-019 ERRCNT[15:0]: count of cycles with DLS_ERROR=1; saturates at 0xFFFF; [31:16]=0.
REQ-020 CTRL: [7:0] THRESH, [8] BLANK_EN, [9] IRQ_EN; other bits read 0, writes ignored.
REQ-021 HRDATA is driven combinationally from the latched address and current register values; reads return the pre-update value when a register changes in the same cycle.
REQ-022 HRDATA is 0 when the latched access is not a valid read.
REQ-023 FSM states: OK, SUSPECT, FAULT; 8-bit RUN counter; effective threshold T = max(THRESH,1).
REQ-024 OK: DLS_ERROR=1 -> RUN=1; go to FAULT if T==1, else to SUSPECT. DLS_ERROR=0 -> stay, RUN=0.
REQ-025 SUSPECT: DLS_ERROR=1 -> RUN=RUN+1; go to FAULT when RUN+1>=T. DLS_ERROR=0 -> go to OK, RUN=0.
REQ-026 FAULT: sticky; RUN holds; exited only by CLEAR.
REQ-027 CLEAR: data-phase write with HWDATA[0]=1 -> state=OK, RUN=0, ERRCNT=0 on that edge; overrides DLS_ERROR and ERRCNT increment in the same cycle. HWDATA[0]=0 has no effect.
REQ-028 A THRESH change while in SUSPECT applies from the next comparison; if RUN>=new T at the next error cycle, go to FAULT.
REQ-029 FAULT (STATUS[0]) = (state==FAULT).
REQ-030 RGB_OUT = 8'h00 when FAULT & BLANK_EN, else RGB_IN (combinational mux on registered state).
REQ-031 FAULT_IRQ = FAULT & IRQ_EN.

Reset
REQ-032 While HRESET=1 at a clock edge: state=OK, RUN=0, ERRCNT=0, THRESH=DEFAULT_THRESH, BLANK_EN=1, IRQ_EN=0, latched address phase cleared to invalid.
REQ-033 After reset: HRDATA=0, HREADYOUT=1, FAULT_IRQ=0, RGB_OUT=RGB_IN.
REQ-034 Reset mid-operation (SUSPECT or FAULT) returns to the REQ-032 state on that edge; a pending data-phase write is discarded.

Verification
REQ-035 DLS_ERROR pulses for 3 cycles, T=4 -> SUSPECT with RUN=1,2,3, then OK; FAULT never set; ERRCNT=3.
REQ-036 DLS_ERROR held for 4 cycles, BLANK_EN=1, RGB_IN=8'hA5 -> FAULT after the 4th edge; RGB_OUT=8'h00 from then on; STATUS read = 0x0000_0401 with DLS_ERROR low, RUN=4.
REQ-037 CTRL write 0x0000_0200 (THRESH=0, IRQ_EN=1), then a single DLS_ERROR cycle -> FAULT and FAULT_IRQ=1 after one edge; RGB_OUT=RGB_IN (BLANK_EN=0).
REQ-038 CLEAR write of 1 while in FAULT with DLS_ERROR=1 on the data-phase cycle -> next state OK, RUN=0, ERRCNT=0; FAULT_IRQ deasserts.
REQ-039 DLS_ERROR held 70000 cycles with THRESH=255 -> ERRCNT saturates at 0xFFFF; FAULT set at cycle 255.
REQ-040 HRESET asserted while in FAULT with CTRL=0x3FF -> on the next edge, CTRL reads 0x0000_0104, STATUS reads 0, and RGB_OUT=RGB_IN.

Source files
------------

// File: rtl/vga_fault_monitor.sv
// AHB-Lite supervised fault monitor for a lockstep VGA pair: counts mismatch
// cycles, escalates OK -> SUSPECT -> FAULT, and can blank the pixel output.
module vga_fault_monitor #(
  parameter logic [7:0] DEFAULT_THRESH = 8'd4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic        DLS_ERROR,
  input  logic [7:0]  RGB_IN,
  output logic [7:0]  RGB_OUT,
  output logic        FAULT_IRQ
);

  typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_FAULT} state_t;

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_ERRCNT = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_CLEAR  = 2'd3;

  state_t      state;
  logic [7:0]  run;
  logic [15:0] errcnt;
  logic [7:0]  thresh;
  logic        blank_en;
  logic        irq_en;

  logic        vld_p0;
  logic        write_p0;
  logic [1:0]  addr_p0;

  logic        access;
  logic        wr_dp;
  logic        ctrl_wr;
  logic        clr;
  logic        fault;
  logic [8:0]  run_next;
  logic        run_hit;
  logic        unused_bits;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A programmed threshold of zero behaves like one.
  function automatic logic [7:0] eff_thresh(input logic [7:0] t);
    return (t == 8'd0) ? 8'd1 : t;
  endfunction

  assign access   = HSEL & HREADY & HTRANS[1];
  assign wr_dp    = vld_p0 & write_p0;
  assign ctrl_wr  = wr_dp & (addr_p0 == A_CTRL);
  assign clr      = wr_dp & (addr_p0 == A_CLEAR) & HWDATA[0];
  assign fault    = (state == ST_FAULT);
  assign run_next = {1'b0, run} + 9'd1;
  assign run_hit  = run_next >= {1'b0, eff_thresh(thresh)};

  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:10]};

  // Address phase -> data phase
  always_ff @(posedge HCLK) begin
    if (HRESET) vld_p0 <= 1'b0;
    else        vld_p0 <= access;
  end

  always_ff @(posedge HCLK) begin
    write_p0 <= HWRITE;
    addr_p0  <= HADDR[3:2];
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      thresh   <= DEFAULT_THRESH;
      blank_en <= 1'b1;
      irq_en   <= 1'b0;
    end else if (ctrl_wr) begin
      thresh   <= HWDATA[7:0];
      blank_en <= HWDATA[8];
      irq_en   <= HWDATA[9];
    end
  end

  // CLEAR wins over a coincident mismatch cycle.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_OK;
      run   <= 8'd0;
    end else if (clr) begin
      state <= ST_OK;
      run   <= 8'd0;
    end else begin
      case (state)
        ST_OK: begin
          if (DLS_ERROR) begin
            run   <= 8'd1;
            state <= run_hit ? ST_FAULT : ST_SUSPECT;
          end else begin
            run <= 8'd0;
          end
        end
        ST_SUSPECT: begin
          if (DLS_ERROR) begin
            run <= run_next[7:0];
            if (run_hit) state <= ST_FAULT;
          end else begin
            state <= ST_OK;
            run   <= 8'd0;
          end
        end
        default: begin
          state <= ST_FAULT;
          run   <= run;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET || clr)  errcnt <= 16'd0;
    else if (DLS_ERROR) errcnt <= sat_inc16(errcnt);
  end

  always_comb begin
    HRDATA = 32'd0;
    if (vld_p0 && !write_p0) begin
      case (addr_p0)
        A_STATUS: HRDATA = {16'd0, run, 4'd0, (state == ST_SUSPECT), FAULT_IRQ, DLS_ERROR, fault};
        A_ERRCNT: HRDATA = {16'd0, errcnt};
        A_CTRL:   HRDATA = {22'd0, irq_en, blank_en, thresh};
        default:  HRDATA = 32'd0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign FAULT_IRQ = fault & irq_en;
  assign RGB_OUT   = (fault && blank_en) ? 8'h00 : RGB_IN;

endmodule

// File: tb/tb_vga_fault_monitor.sv
// Bench for vga_fault_monitor: directed scenarios plus randomized bus/error
// traffic compared every cycle against a run-length reference model.
module tb_vga_fault_monitor;

  logic        HCLK;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        DLS_ERROR;
  logic [7:0]  RGB_IN;
  logic [7:0]  RGB_OUT;
  logic        FAULT_IRQ;

  int n_chk = 0;
  int n_err = 0;

  vga_fault_monitor #(.DEFAULT_THRESH(8'd4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .DLS_ERROR(DLS_ERROR), .RGB_IN(RGB_IN),
    .RGB_OUT(RGB_OUT), .FAULT_IRQ(FAULT_IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Reference model: fault is sticky once the consecutive-error run reaches
  // the effective threshold; the run length itself is the SUSPECT indicator.
  bit m_fault, m_blank, m_irq, m_vld, m_wr, m_dwr;
  int m_run, m_errcnt, m_thresh, m_t, m_addr;

  always @(posedge HCLK) begin
    if (HRESET) begin
      m_fault = 0; m_run = 0; m_errcnt = 0; m_thresh = 4;
      m_blank = 1; m_irq = 0; m_vld = 0; m_wr = 0; m_addr = 0;
    end else begin
      m_t   = (m_thresh == 0) ? 1 : m_thresh;
      m_dwr = m_vld && m_wr;
      if (m_dwr && m_addr == 2) begin
        m_thresh = int'(HWDATA[7:0]);
        m_blank  = HWDATA[8];
        m_irq    = HWDATA[9];
      end
      if (m_dwr && m_addr == 3 && HWDATA[0]) begin
        m_fault = 0; m_run = 0; m_errcnt = 0;
      end else begin
        if (DLS_ERROR && m_errcnt < 65535) m_errcnt++;
        if (!m_fault) begin
          if (DLS_ERROR) begin
            m_run++;
            if (m_run >= m_t) m_fault = 1;
          end else begin
            m_run = 0;
          end
        end
      end
      m_vld  = HSEL && HREADY && HTRANS[1];
      m_wr   = HWRITE;
      m_addr = int'(HADDR[3:2]);
    end
  end

  function automatic logic [31:0] exp_rdata();
    logic [31:0] r;
    r = 32'd0;
    if (m_vld && !m_wr) begin
      case (m_addr)
        0: r = {16'd0, 8'(m_run), 4'd0, 1'(!m_fault && m_run > 0),
                1'(m_fault && m_irq), DLS_ERROR, m_fault};
        1: r = 32'(m_errcnt);
        2: r = {22'd0, m_irq, m_blank, 8'(m_thresh)};
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("hrdata", HRDATA, exp_rdata());
    check("hreadyout", 32'(HREADYOUT), 32'd1);
    check("fault_irq", 32'(FAULT_IRQ), 32'(m_fault && m_irq));
    check("rgb_out", 32'(RGB_OUT), (m_fault && m_blank) ? 32'd0 : 32'(RGB_IN));
  endtask

  // One clock: drive at negedge, check combinational outputs, wait an edge.
  task automatic cyc(input logic sel, input logic wr, input logic [1:0] a,
                     input logic [31:0] wd, input logic err, output logic [31:0] rdata);
    HSEL      = sel;
    HTRANS    = sel ? 2'b10 : 2'b00;
    HWRITE    = wr;
    HREADY    = 1'b1;
    HADDR     = ($urandom() & 32'hFFFF_FFF3) | {28'd0, a, 2'b00};
    HWDATA    = wd;
    DLS_ERROR = err;
    #1;
    rdata = HRDATA;
    compare_all();
    @(negedge HCLK);
  endtask

  task automatic idle(input logic err);
    logic [31:0] d;
    cyc(1'b0, 1'b0, 2'd0, $urandom(), err, d);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] data, input logic err);
    logic [31:0] d;
    cyc(1'b1, 1'b1, a, $urandom(), err, d);
    cyc(1'b0, 1'b0, 2'd0, data, err, d);
  endtask

  task automatic rd(input logic [1:0] a, input logic err, output logic [31:0] rdata);
    logic [31:0] d;
    cyc(1'b1, 1'b0, a, $urandom(), err, d);
    cyc(1'b0, 1'b0, 2'd0, $urandom(), err, rdata);
  endtask

  logic [31:0] rv;
  logic [31:0] dmy;

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = 32'd0; HTRANS = 2'b00; HWRITE = 1'b0;
    HREADY = 1'b1; HWDATA = 32'd0; DLS_ERROR = 1'b0; RGB_IN = 8'h3C;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;

    // Post-reset state
    cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, rv);
    check("rst_hrdata", rv, 32'd0);
    check("rst_irq", 32'(FAULT_IRQ), 32'd0);
    check("rst_rgb", 32'(RGB_OUT), 32'h3C);
    rd(2'd2, 1'b0, rv); check("rst_ctrl", rv, 32'h0000_0104);
    rd(2'd0, 1'b0, rv); check("rst_status", rv, 32'd0);

    // Three-cycle burst below threshold 4
    repeat (3) idle(1'b1);
    idle(1'b0);
    rd(2'd1, 1'b0, rv); check("burst3_errcnt", rv, 32'd3);
    rd(2'd0, 1'b0, rv); check("burst3_status", rv, 32'd0);

    // Four consecutive errors reach FAULT and blank the pixels
    RGB_IN = 8'hA5;
    repeat (4) idle(1'b1);
    idle(1'b0);
    check("fault_blank", 32'(RGB_OUT), 32'd0);
    rd(2'd0, 1'b0, rv); check("fault_status", rv, 32'h0000_0401);

    // IRQ enable, blanking off while in FAULT
    wr(2'd2, 32'h0000_0200, 1'b0);
    check("irq_on", 32'(FAULT_IRQ), 32'd1);
    check("noblank_rgb", 32'(RGB_OUT), 32'hA5);

    // CLEAR with a coincident error
    wr(2'd3, 32'd1, 1'b1);
    check("clr_irq", 32'(FAULT_IRQ), 32'd0);
    rd(2'd1, 1'b0, rv); check("clr_errcnt", rv, 32'd0);
    rd(2'd0, 1'b0, rv); check("clr_status", rv, 32'd0);

    // Threshold 0 acts as 1: a single error faults
    idle(1'b1);
    check("thr0_irq", 32'(FAULT_IRQ), 32'd1);
    rd(2'd0, 1'b0, rv); check("thr0_status", rv, 32'h0000_0105);
    wr(2'd3, 32'd0, 1'b0);
    rd(2'd0, 1'b0, rv); check("clr0_noop", rv, 32'h0000_0105);
    wr(2'd3, 32'd1, 1'b0);

    // Threshold lowered in SUSPECT applies from the next error
    wr(2'd2, 32'h0000_010A, 1'b0);
    repeat (3) idle(1'b1);
    wr(2'd2, 32'h0000_0102, 1'b1);
    idle(1'b1);
    idle(1'b0);
    rd(2'd0, 1'b0, rv); check("thr_lower_status", rv, 32'h0000_0601);

    // Reset in FAULT, with a CTRL write pending in its data phase
    wr(2'd2, 32'h0000_03FF, 1'b0);
    cyc(1'b1, 1'b1, 2'd2, $urandom(), 1'b0, dmy);
    HRESET = 1'b1;
    cyc(1'b0, 1'b0, 2'd0, 32'h0000_02FF, 1'b1, dmy);
    HRESET = 1'b0;
    check("rst_fault_rgb", 32'(RGB_OUT), 32'hA5);
    check("rst_fault_irq", 32'(FAULT_IRQ), 32'd0);
    rd(2'd2, 1'b0, rv); check("rst_fault_ctrl", rv, 32'h0000_0104);
    rd(2'd0, 1'b0, rv); check("rst_fault_status", rv, 32'd0);

    // Long error run: ERRCNT saturates, FAULT at the 255th error
    wr(2'd2, 32'h0000_01FF, 1'b0);
    wr(2'd3, 32'd1, 1'b0);
    RGB_IN = 8'h5A;
    for (int i = 0; i < 70000; i++) begin
      idle(1'b1);
      if (i == 253) check("thr255_pre", 32'(RGB_OUT), 32'h5A);
      if (i == 254) check("thr255_fault", 32'(RGB_OUT), 32'd0);
    end
    rd(2'd1, 1'b1, rv); check("errcnt_sat", rv, 32'h0000_FFFF);
    wr(2'd3, 32'd1, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      HRESET = ($urandom_range(0, 299) == 0);
      HSEL   = 1'($urandom());
      HTRANS = 2'($urandom());
      HWRITE = 1'($urandom());
      HREADY = ($urandom_range(0, 4) != 0);
      HADDR  = $urandom();
      HWDATA = $urandom();
      if ($urandom_range(0, 1) == 1) HWDATA[7:0] = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 4) == 0) DLS_ERROR = ~DLS_ERROR;
      RGB_IN = 8'($urandom());
      #1;
      compare_all();
      @(negedge HCLK);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
